// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR decoder: FSM state encoding and pulse-width windows.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// All window limits are in microseconds and sized to the 14-bit phase counter.
package ir_pkg;

  localparam int PHASE_W = 14;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t PHASE_SAT = 14'd16383;

  // Leader mark (9 ms nominal)
  localparam phase_t LEAD_MARK_MIN  = 14'd8000;
  localparam phase_t LEAD_MARK_MAX  = 14'd10000;
  // Leader space before data (4.5 ms nominal)
  localparam phase_t LEAD_SPACE_MIN = 14'd4000;
  localparam phase_t LEAD_SPACE_MAX = 14'd5000;
  // Leader space before a repeat mark (2.25 ms nominal)
  localparam phase_t REP_SPACE_MIN  = 14'd2000;
  localparam phase_t REP_SPACE_MAX  = 14'd2500;
  // Bit, stop and repeat marks (560 us nominal)
  localparam phase_t BIT_MARK_MIN   = 14'd400;
  localparam phase_t BIT_MARK_MAX   = 14'd700;
  // Space encoding a logic 0 (560 us nominal)
  localparam phase_t ZERO_SPACE_MIN = 14'd400;
  localparam phase_t ZERO_SPACE_MAX = 14'd700;
  // Space encoding a logic 1 (1690 us nominal)
  localparam phase_t ONE_SPACE_MIN  = 14'd1400;
  localparam phase_t ONE_SPACE_MAX  = 14'd1900;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK
  } ir_state_t;

  function automatic logic in_window(input phase_t v, input phase_t lo, input phase_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond timebase: one-cycle tick every CLK_FREQ_HZ/1_000_000 clocks.
// Latency: tick is registered; first tick DIV cycles after reset release.
// Backpressure: none, free running.
//
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-low reset
//   tick_out one-cycle pulse per microsecond
module us_tick_gen #(
  parameter int CLK_FREQ_HZ = 74_250_000
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int DIV_RAW = CLK_FREQ_HZ / 1_000_000;
  // Clocks below 1 MHz cannot resolve a microsecond; tick every cycle instead.
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_cnt  <= '0;
      tick_out <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt  <= '0;
      tick_out <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      tick_out <= 1'b0;
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: measures mark/space widths and decodes 32-bit frames and repeats.
// Latency: 3 cycles raw-to-edge, result pulses 1 cycle after the FSM sees the final edge.
// Backpressure: none; outputs are single-cycle pulses that must be captured when seen.
//
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-low reset
//   ir_raw_in   asynchronous demodulated receiver output
//   code_out    last accepted frame, first received bit in bit 31
//   valid_out   pulse when code_out updates
//   repeat_out  pulse on a well-formed repeat frame
//   error_out   pulse on a malformed or timed-out frame
//
// Build option: define NEC_CHECK_EN to reject frames whose command byte
// is not followed by its bitwise complement.
module nec_ir_decoder #(
  parameter int CLK_FREQ_HZ   = 74_250_000,
  parameter int IR_ACTIVE_LOW = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_raw_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        error_out
);

  import ir_pkg::*;

  // Receiver level when no carrier is present.
  localparam logic IDLE_LVL = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // ---------------------------------------------------------------
  // Synchronizer, polarity normalization and edge detection
  // ---------------------------------------------------------------
  logic sync1, sync2;
  logic mark_now, mark_q;
  logic rise_q, fall_q;

  assign mark_now = sync2 ^ IDLE_LVL;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync1  <= IDLE_LVL;
      sync2  <= IDLE_LVL;
      mark_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1  <= ir_raw_in;
      sync2  <= sync1;
      mark_q <= mark_now;
      rise_q <= mark_now & ~mark_q;
      fall_q <= ~mark_now & mark_q;
    end
  end

  // ---------------------------------------------------------------
  // Microsecond phase counter
  // ---------------------------------------------------------------
  logic   us_tick;
  phase_t phase_q;

  us_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(us_tick)
  );

  // A tick landing on the edge cycle already belongs to the new phase, so
  // the counter reads whole microseconds elapsed since the last edge.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phase_q <= '0;
    end else if (rise_q || fall_q) begin
      phase_q <= {{(PHASE_W-1){1'b0}}, us_tick};
    end else if (us_tick && (phase_q != PHASE_SAT)) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Frame checksum option
  // ---------------------------------------------------------------
  logic [31:0] shift_q, shift_d;
  logic        check_ok;

`ifdef NEC_CHECK_EN
  assign check_ok = (shift_q[15:8] == ~shift_q[7:0]);
`else
  assign check_ok = 1'b1;
`endif

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  ir_state_t state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic       fail, accept, rep_hit;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fail    = 1'b0;
    accept  = 1'b0;
    rep_hit = 1'b0;

    // Each non-idle state ends on one edge type; absent that edge, a
    // counter beyond the state's window maximum aborts without waiting.
    case (state_q)
      IDLE: begin
        if (rise_q) state_d = LEAD_MARK;
      end

      LEAD_MARK: begin
        if (fall_q) begin
          if (in_window(phase_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
          else                                                  fail    = 1'b1;
        end else if (phase_q > LEAD_MARK_MAX) begin
          fail = 1'b1;
        end
      end

      LEAD_SPACE: begin
        if (rise_q) begin
          if (in_window(phase_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_d = BIT_MARK;
            bit_d   = '0;
            shift_d = '0;
          end else if (in_window(phase_q, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_d = REP_MARK;
          end else begin
            fail = 1'b1;
          end
        end else if (phase_q > LEAD_SPACE_MAX) begin
          fail = 1'b1;
        end
      end

      BIT_MARK: begin
        if (fall_q) begin
          if (in_window(phase_q, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
          else                                                fail    = 1'b1;
        end else if (phase_q > BIT_MARK_MAX) begin
          fail = 1'b1;
        end
      end

      BIT_SPACE: begin
        if (rise_q) begin
          if (in_window(phase_q, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
            shift_d = {shift_q[30:0], 1'b0};
          end else if (in_window(phase_q, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
            shift_d = {shift_q[30:0], 1'b1};
          end else begin
            fail = 1'b1;
          end
          if (!fail) begin
            bit_d   = bit_q + 5'd1;
            state_d = (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
          end
        end else if (phase_q > ONE_SPACE_MAX) begin
          fail = 1'b1;
        end
      end

      STOP_MARK: begin
        if (fall_q) begin
          if (in_window(phase_q, BIT_MARK_MIN, BIT_MARK_MAX) && check_ok) begin
            accept  = 1'b1;
            state_d = IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (phase_q > BIT_MARK_MAX) begin
          fail = 1'b1;
        end
      end

      REP_MARK: begin
        if (fall_q) begin
          if (in_window(phase_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            rep_hit = 1'b1;
            state_d = IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (phase_q > BIT_MARK_MAX) begin
          fail = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Any failure drops the partial frame; code_out keeps its last value.
    if (fail) begin
      state_d = IDLE;
      bit_d   = '0;
      shift_d = '0;
    end
  end

  // ---------------------------------------------------------------
  // Registered result pulses
  // ---------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      code_out   <= '0;
      valid_out  <= 1'b0;
      repeat_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      valid_out  <= accept;
      repeat_out <= rep_hit;
      error_out  <= fail;
      if (accept) code_out <= shift_q;
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder: randomized NEC bursts, window-rule model, scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_nec_ir_decoder;

  localparam int EV_VALID  = 0;
  localparam int EV_REPEAT = 1;
  localparam int EV_ERROR  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ir_raw_in;
  logic [31:0] code_out;
  logic        valid_out;
  logic        repeat_out;
  logic        error_out;

  always #5 clk_in = ~clk_in;

  // 1 MHz clock gives one microsecond per cycle.
  nec_ir_decoder #(
    .CLK_FREQ_HZ  (1_000_000),
    .IR_ACTIVE_LOW(1)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ir_raw_in (ir_raw_in),
    .code_out  (code_out),
    .valid_out (valid_out),
    .repeat_out(repeat_out),
    .error_out (error_out)
  );

  typedef struct {
    int          kind;
    logic [31:0] code;
  } ev_t;

  ev_t         exp_q[$];
  int          ph[$];       // alternating mark/space durations in us, mark first
  logic [31:0] model_code;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_w(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic push_ev(input int kind, input logic [31:0] code);
    ev_t e;
    e.kind = kind;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Classifies the burst in ph[] by the NEC timing rules; a burst starts
  // with the decoder idle and its last element is held as long as given.
  task automatic model_burst();
    logic [31:0] sh;
    bit          ok;
    int          i;
    sh = '0;
    ok = 1'b1;
    if (ph.size() < 2 || !in_w(ph[0], 8000, 10000)) begin
      push_ev(EV_ERROR, '0);
    end else if (in_w(ph[1], 2000, 2500)) begin
      if (ph.size() > 2 && in_w(ph[2], 400, 700)) push_ev(EV_REPEAT, model_code);
      else                                        push_ev(EV_ERROR, '0);
    end else if (in_w(ph[1], 4000, 5000)) begin
      for (int b = 0; b < 32; b++) begin
        i = 2 + 2 * b;
        if (i + 1 >= ph.size() || !in_w(ph[i], 400, 700)) begin
          ok = 1'b0;
          break;
        end
        if (in_w(ph[i+1], 400, 700))        sh = {sh[30:0], 1'b0};
        else if (in_w(ph[i+1], 1400, 1900)) sh = {sh[30:0], 1'b1};
        else begin
          ok = 1'b0;
          break;
        end
      end
      if (ok && (ph.size() < 67 || !in_w(ph[66], 400, 700))) ok = 1'b0;
`ifdef NEC_CHECK_EN
      if (ok && (sh[15:8] != ~sh[7:0])) ok = 1'b0;
`endif
      if (ok) begin
        model_code = sh;
        push_ev(EV_VALID, sh);
      end else begin
        push_ev(EV_ERROR, '0);
      end
    end else begin
      push_ev(EV_ERROR, '0);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic build_frame(input int lead_mark, input int lead_space, input logic [31:0] code);
    int m, s;
    ph.delete();
    ph.push_back(lead_mark);
    ph.push_back(lead_space);
    for (int b = 0; b < 32; b++) begin
      // first two marks sit exactly on the window limits
      m = (b == 0) ? 400 : (b == 1) ? 700 : int'($urandom_range(400, 460));
      s = code[31-b] ? int'($urandom_range(1400, 1450)) : int'($urandom_range(400, 450));
      ph.push_back(m);
      ph.push_back(s);
    end
    ph.push_back(int'($urandom_range(400, 700)));
  endtask

  task automatic drive_phases(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ir_raw_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (ph[i]) @(negedge clk_in);
    end
  endtask

  task automatic idle(input int n);
    ir_raw_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic run_burst();
    model_burst();
    drive_phases(0, ph.size() - 1);
    idle(300);
  endtask

  task automatic set_ph3(input int a, input int b, input int c);
    ph.delete();
    ph.push_back(a);
    ph.push_back(b);
    ph.push_back(c);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && (valid_out || repeat_out || error_out)) begin
      ev_t e;
      if (error_out) n_err_seen++;
      check("pulse exclusive", 32'($countones({valid_out, repeat_out, error_out})), 32'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected pulse: got v=%0b r=%0b e=%0b, required none",
                 valid_out, repeat_out, error_out);
      end else begin
        e = exp_q.pop_front();
        check("event kind", (valid_out ? 32'd0 : repeat_out ? 32'd1 : 32'd2), 32'(e.kind));
        if (e.kind != EV_ERROR) check("event code_out", code_out, e.code);
      end
    end
  end

  initial begin
    repeat (500_000) @(posedge clk_in);
    $display("FAIL watchdog: got no finish after 500000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          err_before;
    logic [7:0]  addr, cmd;
    rst_in     = 1'b0;
    ir_raw_in  = 1'b1;
    model_code = '0;
    repeat (10) @(negedge clk_in);
    check("reset code_out", code_out, 32'h0);
    check("reset pulses", {29'b0, valid_out, repeat_out, error_out}, 32'h0);
    rst_in = 1'b1;
    idle(50);

    // leader just outside the window
    ph.delete(); ph.push_back(7999);  run_burst();
    ph.delete(); ph.push_back(10001); run_burst();

    // start key with an 8000 us leader
    build_frame(8000, int'($urandom_range(4000, 4100)), 32'h20DF_5BA4);
    run_burst();
    check("start key code_out", code_out, 32'h20DF_5BA4);

    // repeat frames, nominal and with the longest leader
    set_ph3(9000, 2250, 560);  run_burst();
    check("code after repeat", code_out, 32'h20DF_5BA4);
    set_ph3(10000, 2250, 560); run_burst();

    // bit space held at 2500 us; the next leader follows directly
    ph.delete();
    ph.push_back(9000); ph.push_back(4500); ph.push_back(560); ph.push_back(2500);
    model_burst();
    err_before = n_err_seen;
    drive_phases(0, 2);
    ir_raw_in = 1'b1;
    repeat (1950) @(negedge clk_in);
    check("timeout before space end", 32'(n_err_seen - err_before), 32'd1);
    repeat (550) @(negedge clk_in);

    build_frame(9000, 4500, 32'h20DF_5BA5);
    run_burst();
    check("code after 5BA5 frame", code_out, model_code);

    // reset during the bit-16 mark
    build_frame(9000, 4500, $urandom);
    drive_phases(0, 33);
    ir_raw_in = 1'b0;
    repeat (300) @(negedge clk_in);
    rst_in    = 1'b0;
    ir_raw_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check("code_out in reset", code_out, 32'h0);
    model_code = '0;
    rst_in = 1'b1;
    idle(300);
    check("code_out after reset", code_out, 32'h0);

    // random well-formed frame after reset
    addr = 8'($urandom);
    cmd  = 8'($urandom);
    build_frame(int'($urandom_range(8800, 9200)), int'($urandom_range(4400, 4600)),
                {addr, ~addr, cmd, ~cmd});
    run_burst();

    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk_in);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("final code_out", code_out, model_code);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
